// File: rtl/ysyx_25010008_axi_arbiter.sv
// Two-master to one-slave AXI4-Lite arbiter: m0 = instruction fetch (read only), m1 = load/store.
// One transaction in flight. The bus stays granted until its response handshake, with round-robin on ties.
module ysyx_25010008_axi_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                  clock,
   input  logic                  reset,
   // m0 read
   input  logic [ADDR_W-1:0]     m0_araddr,
   input  logic                  m0_arvalid,
   output logic                  m0_arready,
   output logic [DATA_W-1:0]     m0_rdata,
   output logic [1:0]            m0_rresp,
   output logic                  m0_rvalid,
   input  logic                  m0_rready,
   // m1 read
   input  logic [ADDR_W-1:0]     m1_araddr,
   input  logic                  m1_arvalid,
   output logic                  m1_arready,
   output logic [DATA_W-1:0]     m1_rdata,
   output logic [1:0]            m1_rresp,
   output logic                  m1_rvalid,
   input  logic                  m1_rready,
   // m1 write
   input  logic [ADDR_W-1:0]     m1_awaddr,
   input  logic                  m1_awvalid,
   output logic                  m1_awready,
   input  logic [DATA_W-1:0]     m1_wdata,
   input  logic [DATA_W/8-1:0]   m1_wstrb,
   input  logic                  m1_wvalid,
   output logic                  m1_wready,
   output logic [1:0]            m1_bresp,
   output logic                  m1_bvalid,
   input  logic                  m1_bready,
   // slave
   output logic [ADDR_W-1:0]     s_araddr,
   output logic                  s_arvalid,
   input  logic                  s_arready,
   input  logic [DATA_W-1:0]     s_rdata,
   input  logic [1:0]            s_rresp,
   input  logic                  s_rvalid,
   output logic                  s_rready,
   output logic [ADDR_W-1:0]     s_awaddr,
   output logic                  s_awvalid,
   input  logic                  s_awready,
   output logic [DATA_W-1:0]     s_wdata,
   output logic [DATA_W/8-1:0]   s_wstrb,
   output logic                  s_wvalid,
   input  logic                  s_wready,
   input  logic [1:0]            s_bresp,
   input  logic                  s_bvalid,
   output logic                  s_bready
);

   typedef enum logic [1:0] {IDLE, RD, WR} state_t;

   state_t state, state_nxt;
   logic   owner, owner_nxt;
   logic   last, last_nxt;
   logic   req0, req1, winner;
   logic   rd_done, wr_done;

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         owner <= 1'b0;
         last  <= 1'b1;
      end else begin
         state <= state_nxt;
         owner <= owner_nxt;
         last  <= last_nxt;
      end
   end

   assign req0    = m0_arvalid;
   assign req1    = m1_arvalid | m1_awvalid;
   // On a tie, the master that did not win last time gets the bus.
   assign winner  = (req0 & req1) ? ~last : req1;
   assign rd_done = s_rvalid & (owner ? m1_rready : m0_rready);
   assign wr_done = s_bvalid & m1_bready;

   always_comb begin
      state_nxt = state;
      owner_nxt = owner;
      last_nxt  = last;
      case (state)
         IDLE: if (req0 | req1) begin
            owner_nxt = winner;
            last_nxt  = winner;
            // m1 with both AR and AW pending takes the read first.
            state_nxt = (winner ? m1_arvalid : m0_arvalid) ? RD : WR;
         end
         RD:      if (rd_done) state_nxt = IDLE;
         WR:      if (wr_done) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      m0_arready = 1'b0;
      m0_rdata   = '0;
      m0_rresp   = '0;
      m0_rvalid  = 1'b0;
      m1_arready = 1'b0;
      m1_rdata   = '0;
      m1_rresp   = '0;
      m1_rvalid  = 1'b0;
      m1_awready = 1'b0;
      m1_wready  = 1'b0;
      m1_bresp   = '0;
      m1_bvalid  = 1'b0;
      s_araddr   = '0;
      s_arvalid  = 1'b0;
      s_rready   = 1'b0;
      s_awaddr   = '0;
      s_awvalid  = 1'b0;
      s_wdata    = '0;
      s_wstrb    = '0;
      s_wvalid   = 1'b0;
      s_bready   = 1'b0;
      case (state)
         RD: begin
            if (owner) begin
               s_araddr   = m1_araddr;
               s_arvalid  = m1_arvalid;
               m1_arready = s_arready;
               m1_rdata   = s_rdata;
               m1_rresp   = s_rresp;
               m1_rvalid  = s_rvalid;
               s_rready   = m1_rready;
            end else begin
               s_araddr   = m0_araddr;
               s_arvalid  = m0_arvalid;
               m0_arready = s_arready;
               m0_rdata   = s_rdata;
               m0_rresp   = s_rresp;
               m0_rvalid  = s_rvalid;
               s_rready   = m0_rready;
            end
         end
         WR: begin
            s_awaddr   = m1_awaddr;
            s_awvalid  = m1_awvalid;
            m1_awready = s_awready;
            s_wdata    = m1_wdata;
            s_wstrb    = m1_wstrb;
            s_wvalid   = m1_wvalid;
            m1_wready  = s_wready;
            m1_bresp   = s_bresp;
            m1_bvalid  = s_bvalid;
            s_bready   = m1_bready;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_ysyx_25010008_axi_arbiter.sv
// Scoreboard bench for the two-master AXI4-Lite arbiter: a transaction-level round-robin model
// predicts grant order and responses, a random-latency slave answers, a monitor pops and compares.
module tb_ysyx_25010008_axi_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;

   logic clock = 1'b0;
   logic reset = 1'b1;

   logic [AW-1:0]   m0_araddr = '0, m1_araddr = '0, m1_awaddr = '0;
   logic            m0_arvalid = 0, m1_arvalid = 0, m1_awvalid = 0, m1_wvalid = 0;
   logic            m0_rready = 0, m1_rready = 0, m1_bready = 0;
   logic [DW-1:0]   m1_wdata = '0;
   logic [DW/8-1:0] m1_wstrb = '0;
   logic            m0_arready, m0_rvalid, m1_arready, m1_rvalid, m1_awready, m1_wready, m1_bvalid;
   logic [DW-1:0]   m0_rdata, m1_rdata;
   logic [1:0]      m0_rresp, m1_rresp, m1_bresp;

   logic [AW-1:0]   s_araddr, s_awaddr;
   logic            s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready;
   logic [DW-1:0]   s_wdata;
   logic [DW/8-1:0] s_wstrb;
   logic            s_arready = 0, s_rvalid = 0, s_awready = 0, s_wready = 0, s_bvalid = 0;
   logic [DW-1:0]   s_rdata = '0;
   logic [1:0]      s_rresp = '0, s_bresp = '0;

   ysyx_25010008_axi_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clock(clock), .reset(reset),
      .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
      .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
      .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
      .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
      .m1_awaddr(m1_awaddr), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
      .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
      .m1_bresp(m1_bresp), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
      .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
      .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
      .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int vectors = 0, miscompares = 0;
   int req_cyc = 0;
   bit rdy_rand = 0;
   logic last_m = 1'b1;

   // Expected traffic: grant {is_write, master, addr}, m0 {resp, data}, m1 {is_write, resp, data}, W {strb, data}
   logic [33:0] exp_grant[$];
   logic [33:0] exp_m0[$];
   logic [34:0] exp_m1[$];
   logic [35:0] exp_w[$];

   // The slave answers deterministically from the address so responses are predictable.
   function automatic logic [31:0] f_rdata(input logic [31:0] a);
      return ((a ^ 32'h8000_0000) * 32'h9E37_79B1) ^ 32'h0000_0413;
   endfunction
   function automatic logic [1:0] f_resp(input logic [31:0] a);
      return a[31] ? 2'b00 : a[5:4];
   endfunction

   function automatic logic [11:0] vr_bits();
      return {m0_arready, m0_rvalid, m1_arready, m1_rvalid, m1_awready, m1_wready, m1_bvalid,
              s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_event(input string name);
      vectors++;
      miscompares++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   // Transaction-level round robin over whoever is still pending.
   task automatic plan_round(input bit r0, input logic [31:0] a0, input bit r1, input logic [31:0] a1,
                             input bit w1, input logic [31:0] aw, input logic [31:0] wd, input logic [3:0] ws);
      bit p0 = r0, p1r = r1, p1w = w1;
      logic win;
      while (p0 || p1r || p1w) begin
         if (p0 && (p1r || p1w)) win = ~last_m;
         else                    win = !p0;
         last_m = win;
         if (!win) begin
            exp_grant.push_back({1'b0, 1'b0, a0});
            exp_m0.push_back({f_resp(a0), f_rdata(a0)});
            p0 = 0;
         end else if (p1r) begin
            exp_grant.push_back({1'b0, 1'b1, a1});
            exp_m1.push_back({1'b0, f_resp(a1), f_rdata(a1)});
            p1r = 0;
         end else begin
            exp_grant.push_back({1'b1, 1'b1, aw});
            exp_w.push_back({ws, wd});
            exp_m1.push_back({1'b1, f_resp(aw), 32'h0});
            p1w = 0;
         end
      end
   endtask

   task automatic wait_hs(input int ch);
      bit hs = 0;
      for (int i = 0; i < 600 && !hs; i++) begin
         @(negedge clock);
         case (ch)
            0:       hs = m0_arvalid && m0_arready;
            1:       hs = m1_arvalid && m1_arready;
            2:       hs = m1_awvalid && m1_awready;
            default: hs = m1_wvalid && m1_wready;
         endcase
      end
      if (!hs) fail_event($sformatf("handshake_timeout ch%0d", ch));
      @(posedge clock); #1;
      case (ch)
         0:       m0_arvalid = 0;
         1:       m1_arvalid = 0;
         2:       m1_awvalid = 0;
         default: m1_wvalid = 0;
      endcase
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_grant.size() + exp_m0.size() + exp_m1.size() + exp_w.size()) != 0 && n < 2000) begin
         @(negedge clock);
         n++;
      end
      if (n >= 2000) fail_event("drain_timeout");
   endtask

   task automatic run_round(input bit r0, input logic [31:0] a0, input bit r1, input logic [31:0] a1,
                            input bit w1, input logic [31:0] aw, input logic [31:0] wd, input logic [3:0] ws);
      plan_round(r0, a0, r1, a1, w1, aw, wd, ws);
      @(posedge clock); #1;
      if (r0) begin m0_araddr = a0; m0_arvalid = 1; end
      if (r1) begin m1_araddr = a1; m1_arvalid = 1; end
      if (w1) begin
         m1_awaddr = aw; m1_awvalid = 1;
         m1_wdata = wd; m1_wstrb = ws; m1_wvalid = 1;
      end
      req_cyc = cyc;
      fork
         if (r0) wait_hs(0);
         if (r1) wait_hs(1);
         if (w1) wait_hs(2);
         if (w1) wait_hs(3);
      join
      drain();
   endtask

   // Master-side ready throttling
   initial forever begin
      @(posedge clock); #1;
      if (rdy_rand) begin
         m0_rready = 1'($urandom_range(0, 1));
         m1_rready = 1'($urandom_range(0, 1));
         m1_bready = 1'($urandom_range(0, 1));
      end
   end

   // Slave: one read and one write at a time, random ready and response latency.
   initial begin
      bit ar_hs, r_hs, aw_hs, w_hs, b_hs, rst_s, rd_busy, aw_got, w_got;
      logic [31:0] ar_cap, aw_cap, rd_addr, wr_addr;
      rd_busy = 0; aw_got = 0; w_got = 0; rd_addr = '0; wr_addr = '0;
      forever begin
         @(negedge clock);
         rst_s  = reset;
         ar_hs  = s_arvalid && s_arready;  ar_cap = s_araddr;
         r_hs   = s_rvalid && s_rready;
         aw_hs  = s_awvalid && s_awready;  aw_cap = s_awaddr;
         w_hs   = s_wvalid && s_wready;
         b_hs   = s_bvalid && s_bready;
         @(posedge clock); #1;
         if (rst_s) begin
            s_arready = 0; s_rvalid = 0; s_awready = 0; s_wready = 0; s_bvalid = 0;
            rd_busy = 0; aw_got = 0; w_got = 0;
         end else begin
            if (ar_hs) begin rd_busy = 1; rd_addr = ar_cap; end
            if (r_hs)  begin s_rvalid = 0; rd_busy = 0; end
            if (rd_busy && !s_rvalid && $urandom_range(0, 2) != 0) begin
               s_rvalid = 1; s_rdata = f_rdata(rd_addr); s_rresp = f_resp(rd_addr);
            end
            s_arready = !rd_busy && ($urandom_range(0, 1) == 1);
            if (aw_hs) begin aw_got = 1; wr_addr = aw_cap; end
            if (w_hs)  w_got = 1;
            if (b_hs)  begin s_bvalid = 0; aw_got = 0; w_got = 0; end
            if (aw_got && w_got && !s_bvalid && $urandom_range(0, 2) != 0) begin
               s_bvalid = 1; s_bresp = f_resp(wr_addr);
            end
            s_awready = !aw_got && ($urandom_range(0, 1) == 1);
            s_wready  = !w_got  && ($urandom_range(0, 1) == 1);
         end
      end
   end

   // Monitor: pops expectations on every DUT handshake, checks grant timing and exclusivity.
   initial begin
      bit act, act_prev, waiting;
      int hs_cyc;
      logic [33:0] g;
      logic [34:0] e;
      logic [35:0] w;
      act_prev = 0; waiting = 0; hs_cyc = 0;
      forever begin
         @(negedge clock);
         if (reset) begin
            act_prev = 0; waiting = 0;
            continue;
         end
         act = s_arvalid | s_awvalid | s_wvalid;
         if (act && !act_prev) begin
            if (waiting) check("bubble_gap", 64'(cyc - hs_cyc), 64'd2);
            else         check("grant_latency", 64'(cyc - req_cyc), 64'd1);
         end
         act_prev = act;
         check("exclusive", 64'({m0_rvalid & m1_rvalid, s_arvalid & (s_awvalid | s_wvalid),
                                 m0_arready & m1_arready}), 64'd0);
         if (s_arvalid && s_arready) begin
            if (exp_grant.size() == 0) fail_event("unexpected_ar");
            else begin
               g = exp_grant.pop_front();
               check("ar_grant", 64'({1'b0, m1_arready, m0_arready, s_araddr}),
                     64'({g[33], g[32], ~g[32], g[31:0]}));
            end
         end
         if (s_awvalid && s_awready) begin
            if (exp_grant.size() == 0) fail_event("unexpected_aw");
            else begin
               g = exp_grant.pop_front();
               check("aw_grant", 64'({1'b1, m1_awready, s_awaddr}), 64'({g[33], g[32], g[31:0]}));
            end
         end
         if (s_wvalid && s_wready) begin
            if (exp_w.size() == 0) fail_event("unexpected_w");
            else begin
               w = exp_w.pop_front();
               check("w_data", 64'({m1_wready, s_wstrb, s_wdata}), 64'({1'b1, w}));
            end
         end
         if (m0_rvalid && m0_rready) begin
            if (exp_m0.size() == 0) fail_event("unexpected_m0_r");
            else check("m0_r", 64'({m0_rresp, m0_rdata}), 64'(exp_m0.pop_front()));
         end
         if (m1_rvalid && m1_rready) begin
            if (exp_m1.size() == 0) fail_event("unexpected_m1_r");
            else begin
               e = exp_m1.pop_front();
               check("m1_r", 64'({1'b0, m1_rresp, m1_rdata}), 64'(e));
            end
         end
         if (m1_bvalid && m1_bready) begin
            if (exp_m1.size() == 0) fail_event("unexpected_m1_b");
            else begin
               e = exp_m1.pop_front();
               check("m1_b", 64'({1'b1, m1_bresp, 32'h0}), 64'(e));
            end
         end
         if ((s_rvalid && s_rready) || (s_bvalid && s_bready)) begin
            hs_cyc  = cyc;
            waiting = m0_arvalid | m1_arvalid | m1_awvalid;
         end
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      bit r0, r1, w1, got;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("reset_vr", 64'(vr_bits()), 64'd0);
      check("reset_s_addr", {s_araddr, s_awaddr}, 64'd0);
      check("reset_s_w", 64'({s_wdata, s_wstrb}), 64'd0);
      check("reset_m_data", {m0_rdata, m1_rdata}, 64'd0);
      @(posedge clock); #1;
      reset = 0;
      rdy_rand = 1;

      // directed cases
      run_round(1, 32'h1000_0040, 1, 32'h2000_0080, 0, 0, 0, 0);
      run_round(1, 32'h8000_0000, 0, 0, 0, 0, 0, 0);
      run_round(1, 32'h1000_0044, 1, 32'h2000_0084, 0, 0, 0, 0);
      run_round(0, 0, 0, 0, 1, 32'hA000_03F8, 32'h0000_0041, 4'h1);
      run_round(0, 0, 1, 32'h3000_0010, 1, 32'h3000_0020, 32'hDEAD_BEEF, 4'hF);
      run_round(0, 0, 1, 32'h0000_0020, 0, 0, 0, 0);
      run_round(1, 32'h0000_0030, 1, 32'h0000_0010, 1, 32'h0000_0020, 32'h1234_5678, 4'h6);

      for (int i = 0; i < 60; i++) begin
         r0 = 1'($urandom_range(0, 1));
         r1 = 1'($urandom_range(0, 1));
         w1 = 1'($urandom_range(0, 1));
         if (!(r0 || r1 || w1)) r0 = 1;
         run_round(r0, $urandom, r1, $urandom, w1, $urandom, $urandom, 4'($urandom));
      end

      // reset while an R beat is waiting on the master
      rdy_rand = 0;
      @(posedge clock); #1;
      m0_rready = 0;
      exp_grant.push_back({1'b0, 1'b0, 32'h8000_0100});
      last_m = 1'b0;
      m0_araddr = 32'h8000_0100;
      m0_arvalid = 1;
      req_cyc = cyc;
      wait_hs(0);
      got = 0;
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge clock);
         got = m0_rvalid;
      end
      if (!got) fail_event("reset_test_rvalid_timeout");
      @(posedge clock); #1;
      reset = 1;
      @(posedge clock); #1;
      reset = 0;
      check("reset_mid_read_vr", 64'(vr_bits()), 64'd0);
      last_m = 1'b1;
      exp_grant.delete(); exp_m0.delete(); exp_m1.delete(); exp_w.delete();
      rdy_rand = 1;
      run_round(1, 32'h4000_0000, 1, 32'h5000_0000, 0, 0, 0, 0);

      repeat (3) @(posedge clock);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
